// File: rtl/spi_byte_sequencer.sv
// Multi-byte SPI transaction sequencer. Fetches TX bytes over valid/ready, runs the
// byte master one byte at a time, returns RX bytes, and enforces the inter-byte gap and watchdog.
//
// state | meaning
// IDLE  | waiting for start; a bad length pulses err and stays here
// FETCH | tx_ready high, waiting for the next TX byte
// XFER  | spi_en high, waiting for payload_done or watchdog expiry
// GAP   | spi_en low for GAP_CYCLES, then next byte or completion
module spi_byte_sequencer #(
    parameter int MAX_LEN        = 16,
    parameter int GAP_CYCLES     = 2,
    parameter int TIMEOUT_CYCLES = 4096,
    localparam int LEN_W         = $clog2(MAX_LEN + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             abort,
    input  logic [7:0]       tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    output logic [7:0]       rx_data,
    output logic             rx_valid,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic             spi_en,
    output logic [7:0]       spi_mosi_data,
    input  logic [7:0]       spi_miso_data,
    input  logic             payload_done
);

    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam int WD_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    // Both timers are down-counters loaded with (N-1) and expire on zero.
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYCLES - 1);
    localparam logic [WD_W-1:0]  WD_LOAD  = WD_W'(TIMEOUT_CYCLES - 1);
    localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(MAX_LEN);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_XFER,
        ST_GAP
    } state_t;

    state_t           state;
    logic [LEN_W-1:0] remaining;
    logic [GAP_W-1:0] gap_cnt;
    logic [WD_W-1:0]  wd_cnt;

    assign tx_ready = (state == ST_FETCH);
    assign busy     = (state != ST_IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= ST_IDLE;
            remaining     <= '0;
            gap_cnt       <= '0;
            wd_cnt        <= '0;
            rx_data       <= '0;
            rx_valid      <= 1'b0;
            done          <= 1'b0;
            err           <= 1'b0;
            spi_en        <= 1'b0;
            spi_mosi_data <= '0;
        end else begin
            rx_valid <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        if (len == '0 || len > LEN_MAX) begin
                            err <= 1'b1;
                        end else begin
                            remaining <= len;
                            state     <= ST_FETCH;
                        end
                    end
                end
                ST_FETCH: begin
                    if (abort) begin
                        state <= ST_IDLE;
                    end else if (tx_valid && tx_ready) begin
                        spi_mosi_data <= tx_data;
                        wd_cnt        <= WD_LOAD;
                        spi_en        <= 1'b1;
                        state         <= ST_XFER;
                    end
                end
                ST_XFER: begin
                    // A byte that completes on the watchdog's last cycle still counts.
                    if (abort) begin
                        spi_en <= 1'b0;
                        state  <= ST_IDLE;
                    end else if (payload_done) begin
                        rx_data   <= spi_miso_data;
                        rx_valid  <= 1'b1;
                        remaining <= remaining - 1'b1;
                        gap_cnt   <= GAP_LOAD;
                        spi_en    <= 1'b0;
                        state     <= ST_GAP;
                    end else if (wd_cnt == '0) begin
                        err    <= 1'b1;
                        spi_en <= 1'b0;
                        state  <= ST_IDLE;
                    end else begin
                        wd_cnt <= wd_cnt - 1'b1;
                    end
                end
                ST_GAP: begin
                    if (abort) begin
                        state <= ST_IDLE;
                    end else if (gap_cnt == '0) begin
                        if (remaining == '0) begin
                            done  <= 1'b1;
                            state <= ST_IDLE;
                        end else begin
                            state <= ST_FETCH;
                        end
                    end else begin
                        gap_cnt <= gap_cnt - 1'b1;
                    end
                end
                default: begin
                    spi_en <= 1'b0;
                    state  <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_byte_sequencer.sv
// Scoreboard bench for spi_byte_sequencer: directed scenarios plus randomized
// transactions, with a byte-master model that echoes the inverted TX byte.
module tb_spi_byte_sequencer;

    localparam int MAX_LEN = 16;
    localparam int GAP     = 2;
    localparam int TMO     = 64;
    localparam int LEN_W   = 5;
    localparam int K_RX    = 0;
    localparam int K_DONE  = 1;
    localparam int K_ERR   = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [LEN_W-1:0] len;
    logic             abort;
    logic [7:0]       tx_data;
    logic             tx_valid;
    logic             tx_ready;
    logic [7:0]       rx_data;
    logic             rx_valid;
    logic             busy;
    logic             done;
    logic             err;
    logic             spi_en;
    logic [7:0]       spi_mosi_data;
    logic [7:0]       spi_miso_data;
    logic             payload_done;

    spi_byte_sequencer #(
        .MAX_LEN        (MAX_LEN),
        .GAP_CYCLES     (GAP),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .len           (len),
        .abort         (abort),
        .tx_data       (tx_data),
        .tx_valid      (tx_valid),
        .tx_ready      (tx_ready),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .busy          (busy),
        .done          (done),
        .err           (err),
        .spi_en        (spi_en),
        .spi_mosi_data (spi_mosi_data),
        .spi_miso_data (spi_miso_data),
        .payload_done  (payload_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         kind;
        logic [7:0] data;
    } ev_t;

    ev_t        exp_q[$];
    logic [7:0] mosi_exp[$];
    logic [7:0] tx_bytes[MAX_LEN];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int last_rx  = 0;

    bit         exact_gap    = 1'b0;
    bit         m_silent     = 1'b0;
    bit         m_abort_now  = 1'b0;
    int         m_abort_byte = 0;
    int         m_byte_idx   = 0;
    int         m_cnt        = -1;
    logic [7:0] m_cur        = 8'h00;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic chk_min(input string name, input int act, input int min);
        checks++;
        if (act < min) begin
            failures++;
            $display("FAIL %s actual=%0d required>=%0d", name, act, min);
        end
    endtask

    task automatic pop_cmp(input int kind, input logic [7:0] data);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL event_unexpected actual kind=%0d data=%02h required=none", kind, data);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || (kind == K_RX && e.data !== data)) begin
                failures++;
                $display("FAIL event_order actual kind=%0d data=%02h required kind=%0d data=%02h",
                         kind, data, e.kind, e.data);
            end
        end
    endtask

    // Monitor: pops scoreboard on every DUT strobe, checks gap, mosi stability and idle outputs.
    initial begin
        bit         prev_en   = 1'b0;
        bit         seen_high = 1'b0;
        int         low_run   = 0;
        logic [7:0] prev_mosi = 8'h00;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst) begin
                prev_en   = 1'b0;
                seen_high = 1'b0;
                low_run   = 0;
                continue;
            end
            if (rx_valid) begin
                pop_cmp(K_RX, rx_data);
                last_rx = cyc;
            end
            if (done) begin
                pop_cmp(K_DONE, 8'h00);
                chk("done_after_rx", cyc - last_rx, GAP);
                chk("done_busy", int'(busy), 0);
            end
            if (err) begin
                pop_cmp(K_ERR, 8'h00);
                chk("err_busy", int'(busy), 0);
                chk("err_spi_en", int'(spi_en), 0);
            end
            if (!busy) chk("tx_ready_idle", int'(tx_ready), 0);
            if (spi_en && prev_en) chk("mosi_stable", int'(spi_mosi_data), int'(prev_mosi));
            if (spi_en && !prev_en && seen_high) begin
                if (exact_gap) chk("gap_exact", low_run, GAP + 1);
                else chk_min("gap_min", low_run, GAP + 1);
            end
            if (spi_en) begin
                low_run   = 0;
                seen_high = 1'b1;
            end else begin
                low_run++;
            end
            if (!busy) seen_high = 1'b0;
            prev_en   = spi_en;
            prev_mosi = spi_mosi_data;
        end
    end

    // Byte-master model: answers each spi_en rise with ~byte after a random delay.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            payload_done  = 1'b0;
            spi_miso_data = 8'($urandom);
            if (m_abort_now) begin
                abort       = 1'b0;
                m_abort_now = 1'b0;
                chk("abort_idle_busy", int'(busy), 0);
                chk("abort_spi_en", int'(spi_en), 0);
            end
            if (!rst || !spi_en) begin
                m_cnt = -1;
            end else if (m_cnt < 0) begin
                m_cur = spi_mosi_data;
                m_byte_idx++;
                m_cnt = int'($urandom_range(0, 4));
                if (mosi_exp.size() == 0) chk("mosi_unexpected", 1, 0);
                else chk("mosi_data", int'(spi_mosi_data), int'(mosi_exp.pop_front()));
            end else if (m_cnt > 0) begin
                m_cnt--;
            end
            if (m_cnt == 0 && !m_silent) begin
                payload_done  = 1'b1;
                spi_miso_data = ~m_cur;
                m_cnt         = -1;
                if (m_byte_idx == m_abort_byte) begin
                    abort       = 1'b1;
                    m_abort_now = 1'b1;
                end
            end
        end
    end

    task automatic feed_byte(input logic [7:0] b, input int stall, output bit ok);
        bit seen;
        seen     = 1'b0;
        ok       = 1'b0;
        tx_data  = b;
        tx_valid = (stall == 0);
        for (int k = 0; k < 400 && !seen; k++) begin
            @(negedge clk);
            if (!busy) begin
                tx_valid = 1'b0;
                return;
            end
            if (tx_ready) seen = 1'b1;
        end
        if (!seen) begin
            tx_valid = 1'b0;
            chk("fetch_wait", 0, 1);
            return;
        end
        for (int k = 0; k < stall; k++) begin
            @(negedge clk);
            chk("stall_spi_en", int'(spi_en), 0);
            chk("stall_tx_ready", int'(tx_ready), 1);
        end
        tx_valid = 1'b1;
        mosi_exp.push_back(b);
        @(posedge clk);
        #1;
        tx_valid = 1'b0;
        chk("en_rise", int'(spi_en), 1);
        ok = 1'b1;
    endtask

    // Reference outcome: bad length or silent master -> err; abort on byte k -> k-1 RX, no done;
    // otherwise one RX of ~byte per byte, then done.
    task automatic run_txn(input int L, input int stall_idx, input int stall_len,
                           input int abort_at, input bit silent);
        bit  bad;
        bit  ok;
        int  n_rx;
        int  n;
        ev_t e;
        bad          = (L == 0 || L > MAX_LEN);
        m_silent     = silent;
        m_abort_byte = abort_at;
        m_byte_idx   = 0;
        exact_gap    = (stall_len == 0);
        if (bad || silent) begin
            e.kind = K_ERR;
            e.data = 8'h00;
            exp_q.push_back(e);
        end else begin
            n_rx = (abort_at > 0) ? abort_at - 1 : L;
            for (int i = 0; i < n_rx; i++) begin
                e.kind = K_RX;
                e.data = ~tx_bytes[i];
                exp_q.push_back(e);
            end
            if (abort_at == 0) begin
                e.kind = K_DONE;
                e.data = 8'h00;
                exp_q.push_back(e);
            end
        end
        start = 1'b1;
        len   = LEN_W'(L);
        @(posedge clk);
        #1;
        start = 1'b0;
        if (bad) begin
            chk("bad_busy", int'(busy), 0);
            chk("bad_err", int'(err), 1);
            @(negedge clk);
            return;
        end
        chk("start_busy", int'(busy), 1);
        for (int i = 0; i < L; i++) begin
            feed_byte(tx_bytes[i], (i == stall_idx) ? stall_len : 0, ok);
            if (!ok) break;
            if (silent) begin
                n = 0;
                for (int k = 1; k <= 200 && n == 0; k++) begin
                    @(posedge clk);
                    #1;
                    if (err) n = k;
                end
                chk("timeout_cycles", n, TMO);
                chk("timeout_spi_en", int'(spi_en), 0);
                chk("timeout_busy", int'(busy), 0);
                break;
            end
        end
        n = 0;
        while (busy && n < 600) begin
            @(negedge clk);
            n++;
        end
        if (busy) chk("txn_end", int'(busy), 0);
    endtask

    task automatic drain();
        repeat (4) @(negedge clk);
        chk("drain_events", exp_q.size(), 0);
        chk("drain_mosi", mosi_exp.size(), 0);
        exp_q.delete();
        mosi_exp.delete();
    endtask

    initial begin
        bit ok;
        rst           = 1'b0;
        start         = 1'b0;
        len           = '0;
        abort         = 1'b0;
        tx_data       = 8'h00;
        tx_valid      = 1'b0;
        spi_miso_data = 8'h00;
        payload_done  = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", int'(busy), 0);
        chk("rst_spi_en", int'(spi_en), 0);
        chk("rst_mosi", int'(spi_mosi_data), 0);
        chk("rst_rx_data", int'(rx_data), 0);
        chk("rst_rx_valid", int'(rx_valid), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_err", int'(err), 0);
        chk("rst_tx_ready", int'(tx_ready), 0);
        rst = 1'b1;
        @(negedge clk);

        tx_bytes[0] = 8'hA5;
        run_txn(1, -1, 0, 0, 1'b0);
        drain();

        tx_bytes[0] = 8'h01;
        tx_bytes[1] = 8'h02;
        tx_bytes[2] = 8'h04;
        tx_bytes[3] = 8'h08;
        run_txn(4, 2, 5, 0, 1'b0);
        drain();

        run_txn(0, -1, 0, 0, 1'b0);
        run_txn(17, -1, 0, 0, 1'b0);
        drain();

        tx_bytes[0] = 8'h11;
        tx_bytes[1] = 8'h22;
        tx_bytes[2] = 8'h33;
        run_txn(3, -1, 0, 2, 1'b0);
        tx_bytes[0] = 8'h9C;
        run_txn(1, -1, 0, 0, 1'b0);
        drain();

        tx_bytes[0] = 8'h77;
        run_txn(1, -1, 0, 0, 1'b1);
        drain();

        for (int t = 0; t < 30; t++) begin
            int L, sidx, slen, ab, r;
            r = int'($urandom_range(0, 7));
            if (r == 0) L = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(17, 31));
            else L = int'($urandom_range(1, MAX_LEN));
            for (int i = 0; i < MAX_LEN; i++) tx_bytes[i] = 8'($urandom);
            sidx = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, MAX_LEN - 1)) : -1;
            slen = (sidx >= 0) ? int'($urandom_range(1, 6)) : 0;
            ab   = (L >= 1 && L <= MAX_LEN && $urandom_range(0, 5) == 0) ? int'($urandom_range(1, L)) : 0;
            run_txn(L, sidx, slen, ab, 1'b0);
        end
        drain();

        // Known nonzero rx_data before the mid-transfer reset.
        tx_bytes[0] = 8'h00;
        run_txn(1, -1, 0, 0, 1'b0);
        drain();
        m_silent     = 1'b1;
        m_abort_byte = 0;
        start        = 1'b1;
        len          = LEN_W'(2);
        @(posedge clk);
        #1;
        start = 1'b0;
        feed_byte(8'h5A, 0, ok);
        chk("pre_reset_xfer", int'(ok), 1);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_spi_en", int'(spi_en), 0);
        chk("arst_busy", int'(busy), 0);
        chk("arst_rx_valid", int'(rx_valid), 0);
        chk("arst_mosi", int'(spi_mosi_data), 0);
        chk("arst_rx_data", int'(rx_data), 0);
        repeat (2) @(negedge clk);
        tx_valid = 1'b0;
        exp_q.delete();
        mosi_exp.delete();
        m_silent = 1'b0;
        rst      = 1'b1;
        @(negedge clk);
        tx_bytes[0] = 8'hC3;
        tx_bytes[1] = 8'h3C;
        run_txn(2, -1, 0, 0, 1'b0);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        failures++;
        $display("FAIL global_timeout actual=running required=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
